spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
- REQ-001: Parameter BYTE_W, default 8, SPI byte width; all byte ports use it.
- REQ-002: Parameter ADDR_W, default 3, register address width; ADDR_W SHALL be ≤ BYTE_W-1.
- REQ-003: sys_clk  input  1  single clock; all state on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: csn_pad  input  1  SPI chip select pad, active-low, asynchronous to sys_clk; frame boundary.
- REQ-006: spi_dreq  input  1  level from the SPI peripheral; high = received byte ready and TX byte needed; stays high until spi_data_written.
- REQ-007: spi_data_rx  input  BYTE_W  last received byte; valid while spi_dreq high.
- REQ-008: spi_data_to_send  output  BYTE_W  next TX byte to the SPI peripheral.
- REQ-009: spi_data_written  output  1  one-cycle pulse loading spi_data_to_send into the peripheral and clearing spi_dreq.
- REQ-010: reg_addr  output  ADDR_W  register file address.
- REQ-011: reg_wdata  output  BYTE_W  register write data.
- REQ-012: reg_wr_en  output  1  one-cycle write strobe.
- REQ-013: reg_rdata  input  BYTE_W  combinational register read of reg_addr.
- REQ-014: frame_err  output  1  sticky flag: illegal command seen; cleared only by reset.

Function
- REQ-015: csn_pad SHALL pass through a 2-flop synchronizer (cs_s); spi_dreq SHALL be registered once (dreq_q); a byte event is spi_dreq=1 and dreq_q=0.
- REQ-016: FSM states: IDLE, CMD, WR, RD, DROP.
- REQ-017: IDLE -> CMD when cs_s=0; any state -> IDLE when cs_s=1, with priority over all other events.
- REQ-018: Command byte (first byte event in CMD): bit BYTE_W-1 = 1 write, 0 read; bits [ADDR_W-1:0] = start address; bits [BYTE_W-2:ADDR_W] SHALL be zero.
- REQ-019: Legal command: latch address into addr_ptr; go to WR (write) or RD (read).
- REQ-020: Nonzero reserved bits: set frame_err; go to DROP; DROP acknowledges every byte with TX 0x00 and performs no writes.
- REQ-021: WR byte event at cycle N: at N+1 reg_wr_en=1, reg_addr=addr_ptr, reg_wdata=byte; addr_ptr increments, wrapping 2^ADDR_W-1 -> 0.
- REQ-022: RD, and the read command byte itself: at N+1 reg_addr=addr_ptr; at N+2 spi_data_to_send=reg_rdata sampled at N+1; addr_ptr then increments with wrap. Bytes received in RD are discarded.
- REQ-023: Every byte event SHALL produce exactly one spi_data_written pulse at N+2, with spi_data_to_send valid in the same cycle; response byte is 0x00 for the write command, WR bytes and DROP bytes.
- REQ-024: A byte event is accepted only if cs_s=0 at cycle N; once accepted, its pipeline (wr_en, written pulse) SHALL complete even if cs_s rises at N+1 or N+2, and the FSM still goes to IDLE.
- REQ-025: A byte event during a pending response (N+1, N+2) SHALL NOT occur per protocol; if it does, it SHALL be ignored.
- REQ-026: In IDLE, spi_data_to_send SHALL hold 0x00 and no strobes SHALL fire.

Reset
- REQ-027: While rst=1: state IDLE, addr_ptr=0, reg_addr=0, reg_wdata=0, spi_data_to_send=0, reg_wr_en=0, spi_data_written=0, frame_err=0, synchronizer and dreq_q cleared.
- REQ-028: Reset mid-frame SHALL abort any pending strobe; after release, the FSM resumes at CMD only after cs_s is seen low from IDLE.

Verification
- REQ-029: csn low, bytes 0x82,0x11,0x22 -> reg_wr_en at addr 2 data 0x11, addr 3 data 0x22; three written pulses, TX 0x00 each.
- REQ-030: regs[7]=0xAB, regs[0]=0xCD; csn low, bytes 0x07,x,x -> TX responses 0xAB then 0xCD (wrap 7->0), then 0x??=regs[1].
- REQ-031: Command 0x48 (reserved bit set) -> frame_err=1, DROP, later bytes get 0x00, no reg_wr_en; csn high then 0x81,0x55 -> write addr 1 succeeds, frame_err stays 1.
- REQ-032: Byte event at cycle N with csn deasserting at N+1 -> wr_en and written pulse still occur; FSM in IDLE afterwards; next frame starts in CMD.
- REQ-033: rst asserted one cycle after a WR byte event -> no reg_wr_en, no written pulse, all outputs zero.
- REQ-034: Handshake check over a random frame: exactly one spi_data_written per byte event, always at N+2.

Source files
------------

// File: rtl/spi_reg_bridge_if.sv
// spi_reg_bridge_if: SPI peripheral handshake and register-file bus of the bridge.
interface spi_reg_bridge_if #(
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 3
);
    logic              csn_pad;
    logic              spi_dreq;
    logic [BYTE_W-1:0] spi_data_rx;
    logic [BYTE_W-1:0] spi_data_to_send;
    logic              spi_data_written;
    logic [ADDR_W-1:0] reg_addr;
    logic [BYTE_W-1:0] reg_wdata;
    logic              reg_wr_en;
    logic [BYTE_W-1:0] reg_rdata;
    logic              frame_err;

    modport master (
        input  csn_pad, spi_dreq, spi_data_rx, reg_rdata,
        output spi_data_to_send, spi_data_written, reg_addr, reg_wdata, reg_wr_en, frame_err
    );
    modport slave (
        output csn_pad, spi_dreq, spi_data_rx, reg_rdata,
        input  spi_data_to_send, spi_data_written, reg_addr, reg_wdata, reg_wr_en, frame_err
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns SPI byte frames (command + data) into register reads and writes.
module spi_reg_bridge #(
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 3
) (
    input logic sys_clk,
    input logic rst,
    spi_reg_bridge_if.master bus
);
    localparam logic [BYTE_W-1:0] LOW_MASK = BYTE_W'((1 << ADDR_W) - 1);
    localparam logic [BYTE_W-1:0] RSV_MASK = {1'b0, {(BYTE_W-1){1'b1}}} & ~LOW_MASK;

    typedef enum logic [2:0] {IDLE, CMD, WR, RD, DROP} state_t;
    state_t state, state_n;
    logic cs_m, cs_s, dreq_q, p1, p1_rd;
    logic [ADDR_W-1:0] addr_ptr;
    logic [BYTE_W-1:0] rx;
    logic ev, acc, is_wr, rsv_bad;

    assign rx      = bus.spi_data_rx;
    assign ev      = bus.spi_dreq & ~dreq_q;
    // a second event while a response is still in flight is a protocol violation and is dropped
    assign acc     = ev & ~cs_s & (state != IDLE) & ~p1 & ~bus.spi_data_written;
    assign is_wr   = rx[BYTE_W-1];
    assign rsv_bad = |(rx & RSV_MASK);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cs_m   <= 1'b0;
            cs_s   <= 1'b0;
            dreq_q <= 1'b0;
            state  <= IDLE;
        end else begin
            cs_m   <= bus.csn_pad;
            cs_s   <= cs_m;
            dreq_q <= bus.spi_dreq;
            state  <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        state_n = cs_s                    ? IDLE :
                  (state == IDLE)         ? CMD  :
                  (state == CMD && acc)   ? (rsv_bad ? DROP : is_wr ? WR : RD) :
                  state;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            p1                   <= 1'b0;
            p1_rd                <= 1'b0;
            addr_ptr             <= '0;
            bus.reg_addr         <= '0;
            bus.reg_wdata        <= '0;
            bus.reg_wr_en        <= 1'b0;
            bus.spi_data_to_send <= '0;
            bus.spi_data_written <= 1'b0;
            bus.frame_err        <= 1'b0;
        end else begin
            p1                   <= 1'b0;
            p1_rd                <= 1'b0;
            bus.reg_wr_en        <= 1'b0;
            bus.spi_data_written <= p1;
            if (p1)
                bus.spi_data_to_send <= p1_rd ? bus.reg_rdata : '0;
            else if (state == IDLE)
                bus.spi_data_to_send <= '0;
            if (acc) begin
                p1 <= 1'b1;
                case (state)
                    CMD: begin
                        if (rsv_bad) begin
                            bus.frame_err <= 1'b1;
                        end else if (is_wr) begin
                            addr_ptr <= rx[ADDR_W-1:0];
                        end else begin
                            bus.reg_addr <= rx[ADDR_W-1:0];
                            addr_ptr     <= rx[ADDR_W-1:0] + 1'b1;
                            p1_rd        <= 1'b1;
                        end
                    end
                    WR: begin
                        bus.reg_wr_en <= 1'b1;
                        bus.reg_addr  <= addr_ptr;
                        bus.reg_wdata <= rx;
                        addr_ptr      <= addr_ptr + 1'b1;
                    end
                    RD: begin
                        bus.reg_addr <= addr_ptr;
                        addr_ptr     <= addr_ptr + 1'b1;
                        p1_rd        <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: drives SPI frames into the bridge and checks register traffic and TX bytes
// against a frame-level model of the command protocol.
module tb_spi_reg_bridge;
    localparam int BW = 8;
    localparam int AW = 3;

    logic sys_clk = 1'b0;
    logic rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    spi_reg_bridge_if #(.BYTE_W(BW), .ADDR_W(AW)) bus ();
    spi_reg_bridge #(.BYTE_W(BW), .ADDR_W(AW)) dut (.sys_clk(sys_clk), .rst(rst), .bus(bus));

    logic [7:0] regs [8];
    logic [7:0] mregs [8];
    bit merr = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;
    int written_cnt = 0;
    logic [10:0] wq [$];

    assign bus.reg_rdata = regs[bus.reg_addr];
    always @(posedge sys_clk) if (bus.reg_wr_en) regs[bus.reg_addr] <= bus.reg_wdata;

    always @(negedge sys_clk) begin
        ncyc++;
        if (!rst && bus.reg_wr_en) wq.push_back({bus.reg_addr, bus.reg_wdata});
        if (!rst && bus.spi_data_written) written_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit cs_drop, output logic [7:0] tx);
        int n0;
        bit seen;
        seen = 1'b0;
        tx = 8'h00;
        @(posedge sys_clk); #1;
        bus.spi_data_rx = b;
        bus.spi_dreq = 1'b1;
        n0 = ncyc;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge sys_clk); #1;
            if (cs_drop && i == 1) bus.csn_pad = 1'b1;
            if (bus.spi_data_written) begin
                seen = 1'b1;
                tx = bus.spi_data_to_send;
                chk("written_latency", ncyc - n0, 3);
            end
        end
        if (!seen) chk("written_timeout", 0, 1);
        @(posedge sys_clk); #1;
        bus.spi_dreq = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] fb [$], input bit cs_drop_last);
        logic [7:0] exp_tx [$];
        logic [10:0] exp_w [$];
        logic [7:0] cmd, tx;
        int ptr, w0;
        cmd = fb[0];
        ptr = int'(cmd[2:0]);
        if (cmd[6:3] != 4'd0) begin
            merr = 1'b1;
            foreach (fb[i]) exp_tx.push_back(8'h00);
        end else if (cmd[7]) begin
            exp_tx.push_back(8'h00);
            for (int i = 1; i < fb.size(); i++) begin
                exp_w.push_back({3'(ptr), fb[i]});
                mregs[ptr] = fb[i];
                exp_tx.push_back(8'h00);
                ptr = (ptr + 1) % 8;
            end
        end else begin
            foreach (fb[i]) exp_tx.push_back(mregs[(ptr + i) % 8]);
        end
        wq.delete();
        w0 = written_cnt;
        bus.csn_pad = 1'b0;
        repeat (4) @(posedge sys_clk);
        foreach (fb[i]) begin
            repeat ($urandom_range(0, 2)) @(posedge sys_clk);
            send_byte(fb[i], cs_drop_last && i == fb.size() - 1, tx);
            chk("tx_byte", tx, exp_tx[i]);
        end
        bus.csn_pad = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1;
        chk("pulse_count", written_cnt - w0, fb.size());
        chk("write_count", wq.size(), exp_w.size());
        for (int i = 0; i < wq.size() && i < exp_w.size(); i++) chk("write_addr_data", wq[i], exp_w[i]);
        chk("frame_err", bus.frame_err, merr);
        chk("idle_tx_zero", bus.spi_data_to_send, 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_wr_en"}, bus.reg_wr_en, 0);
        chk({tag, "_written"}, bus.spi_data_written, 0);
        chk({tag, "_to_send"}, bus.spi_data_to_send, 0);
        chk({tag, "_addr"}, bus.reg_addr, 0);
        chk({tag, "_wdata"}, bus.reg_wdata, 0);
        chk({tag, "_frame_err"}, bus.frame_err, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] fb [$];
        logic [7:0] tx, cmd;
        int w0, n0;
        foreach (regs[i]) begin
            regs[i] = 8'($urandom);
            mregs[i] = regs[i];
        end
        bus.csn_pad = 1'b1;
        bus.spi_dreq = 1'b0;
        bus.spi_data_rx = 8'h00;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;
        repeat (6) @(posedge sys_clk);

        fb = '{8'h82, 8'h11, 8'h22};
        run_frame(fb, 1'b0);

        regs[7] = 8'hAB; mregs[7] = 8'hAB;
        regs[0] = 8'hCD; mregs[0] = 8'hCD;
        fb = '{8'h07, 8'h3C, 8'hC3};
        run_frame(fb, 1'b0);

        fb = '{8'h48, 8'h33, 8'h44};
        run_frame(fb, 1'b0);
        fb = '{8'h81, 8'h55};
        run_frame(fb, 1'b0);

        fb = '{8'h85, 8'h9E};
        run_frame(fb, 1'b1);
        fb = '{8'h05, 8'h00};
        run_frame(fb, 1'b0);

        bus.csn_pad = 1'b0;
        repeat (4) @(posedge sys_clk);
        send_byte(8'h82, 1'b0, tx);
        chk("rst_cmd_tx", tx, 0);
        w0 = written_cnt;
        n0 = wq.size();
        @(posedge sys_clk); #1;
        bus.spi_data_rx = 8'h5A;
        bus.spi_dreq = 1'b1;
        @(posedge sys_clk); #1;
        rst = 1'b1;
        repeat (4) @(negedge sys_clk);
        #1;
        chk("rst_no_write", wq.size(), n0);
        chk("rst_no_pulse", written_cnt - w0, 0);
        chk("rst_reg_kept", regs[2], mregs[2]);
        chk_zero_outputs("mid_rst");
        merr = 1'b0;
        bus.spi_dreq = 1'b0;
        bus.csn_pad = 1'b1;
        @(posedge sys_clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge sys_clk);
        fb = '{8'h02, 8'h00};
        run_frame(fb, 1'b0);

        for (int f = 0; f < 25; f++) begin
            cmd = 8'($urandom);
            if ($urandom_range(0, 5) != 0) cmd = cmd & 8'h87;
            fb.delete();
            fb.push_back(cmd);
            repeat ($urandom_range(0, 4)) fb.push_back(8'($urandom));
            run_frame(fb, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
